// File: rtl/mpram_wr_sched_if.sv
// rtl/mpram_wr_sched_if.sv - requester and mpram write-port signals of the write scheduler
interface mpram_wr_sched_if #(
  parameter int MEMD    = 16,
  parameter int DATAW   = 32,
  parameter int nWPORTS = 2,
  parameter int nREQ    = 4
);
  localparam int ADDRW = (MEMD > 1) ? $clog2(MEMD) : 1;

  logic                     hold;
  logic [nREQ-1:0]          req_valid;
  logic [nREQ-1:0]          req_ready;
  logic [ADDRW*nREQ-1:0]    req_addr;
  logic [DATAW*nREQ-1:0]    req_data;
  logic [nWPORTS-1:0]       WEnb;
  logic [ADDRW*nWPORTS-1:0] WAddr;
  logic [DATAW*nWPORTS-1:0] WData;
  logic                     init_done;

  // master: the requester side; slave: the scheduler
  modport master (
    output hold, req_valid, req_addr, req_data,
    input  req_ready, WEnb, WAddr, WData, init_done
  );

  modport slave (
    input  hold, req_valid, req_addr, req_data,
    output req_ready, WEnb, WAddr, WData, init_done
  );
endinterface

// File: rtl/mpram_wr_sched.sv
// rtl/mpram_wr_sched.sv - round-robin scheduler sharing mpram write ports among requesters
module mpram_wr_sched #(
  parameter int MEMD    = 16,
  parameter int DATAW   = 32,
  parameter int nWPORTS = 2,
  parameter int nREQ    = 4,
  parameter int INITZ   = 1
) (
  input logic             clk,
  input logic             rst,
  mpram_wr_sched_if.slave bus
);
  localparam int ADDRW = (MEMD > 1) ? $clog2(MEMD) : 1;
  localparam int PW    = (nREQ > 1) ? $clog2(nREQ) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                   state;
  logic [PW-1:0]            rr_ptr;
  logic [PW-1:0]            rr_nxt;
  logic [ADDRW-1:0]         init_cnt;
  logic [nREQ-1:0]          gnt;
  logic [nWPORTS-1:0]       pwen;
  logic [ADDRW-1:0]         paddr [nWPORTS];
  logic [DATAW-1:0]         pdata [nWPORTS];
  logic [nWPORTS-1:0]       wenb_q;
  logic [ADDRW*nWPORTS-1:0] waddr_q;
  logic [DATAW*nWPORTS-1:0] wdata_q;
  logic                     init_done_q;

  // Scan position k visits requester (rr_ptr+k) mod nREQ; the n-th grant takes port n.
  always_comb begin
    int   ngnt;
    logic clash;
    gnt    = '0;
    pwen   = '0;
    rr_nxt = rr_ptr;
    ngnt   = 0;
    clash  = 1'b0;
    for (int p = 0; p < nWPORTS; p++) begin
      paddr[p] = '0;
      pdata[p] = '0;
    end
    if (!rst && state == RUN && !bus.hold) begin
      for (int k = 0; k < nREQ; k++) begin
        for (int i = 0; i < nREQ; i++) begin
          if (i == (int'(rr_ptr) + k) % nREQ) begin
            clash = 1'b0;
            for (int p = 0; p < nWPORTS; p++) begin
              if (p < ngnt && paddr[p] == bus.req_addr[i*ADDRW +: ADDRW]) clash = 1'b1;
            end
            if (bus.req_valid[i] && ngnt < nWPORTS && !clash) begin
              gnt[i] = 1'b1;
              for (int p = 0; p < nWPORTS; p++) begin
                if (p == ngnt) begin
                  pwen[p]  = 1'b1;
                  paddr[p] = bus.req_addr[i*ADDRW +: ADDRW];
                  pdata[p] = bus.req_data[i*DATAW +: DATAW];
                end
              end
              ngnt   = ngnt + 1;
              rr_nxt = PW'((i + 1) % nREQ);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= (INITZ != 0) ? INIT : RUN;
      rr_ptr      <= '0;
      init_cnt    <= '0;
      wenb_q      <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          wenb_q               <= '0;
          wenb_q[0]            <= 1'b1;
          waddr_q[0 +: ADDRW]  <= init_cnt;
          wdata_q[0 +: DATAW]  <= '0;
          init_cnt             <= init_cnt + ADDRW'(1);
          if (init_cnt == ADDRW'(MEMD - 1)) begin
            state       <= RUN;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          init_done_q <= 1'b1;
          wenb_q      <= pwen;
          // Idle ports keep their last address/data so the mpram bus stays quiet.
          for (int p = 0; p < nWPORTS; p++) begin
            if (pwen[p]) begin
              waddr_q[p*ADDRW +: ADDRW] <= paddr[p];
              wdata_q[p*DATAW +: DATAW] <= pdata[p];
            end
          end
          if (|gnt) rr_ptr <= rr_nxt;
        end
      endcase
    end
  end

  assign bus.req_ready = gnt;
  assign bus.WEnb      = wenb_q;
  assign bus.WAddr     = waddr_q;
  assign bus.WData     = wdata_q;
  assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_mpram_wr_sched.sv
// tb/tb_mpram_wr_sched.sv - randomized self-checking bench for mpram_wr_sched
module tb_mpram_wr_sched;
  localparam int MEMD = 16, DATAW = 32, NW = 2, NR = 4, AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic           v [NR];
  logic [AW-1:0]  a [NR];
  logic [DATAW-1:0] d [NR];

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_init, m_cnt, m_rr;
  int g_idx [$];
  logic [NR-1:0]    e_ready;
  logic [NW-1:0]    e_wenb;
  logic [AW-1:0]    e_waddr [NW];
  logic [DATAW-1:0] e_wdata [NW];
  logic             e_done;

  // emulated mpram fed by the DUT, and one fed by the model
  logic [DATAW-1:0] dut_mem [MEMD];
  logic [DATAW-1:0] ref_mem [MEMD];
  logic [NW-1:0]       s_wenb;
  logic [AW*NW-1:0]    s_waddr;
  logic [DATAW*NW-1:0] s_wdata;

  always #5 clk = ~clk;

  mpram_wr_sched_if #(.MEMD(MEMD), .DATAW(DATAW), .nWPORTS(NW), .nREQ(NR)) bus ();

  mpram_wr_sched #(.MEMD(MEMD), .DATAW(DATAW), .nWPORTS(NW), .nREQ(NR), .INITZ(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [AW*NW-1:0] exp_waddr();
    return {e_waddr[1], e_waddr[0]};
  endfunction

  function automatic logic [DATAW*NW-1:0] exp_wdata();
    return {e_wdata[1], e_wdata[0]};
  endfunction

  task automatic model_reset();
    m_init = 1; m_cnt = 0; m_rr = 0;
    e_wenb = '0; e_done = 1'b0;
    for (int p = 0; p < NW; p++) begin e_waddr[p] = '0; e_wdata[p] = '0; end
  endtask

  // Grants: walk requesters circularly from m_rr, accept while ports remain and address is fresh.
  task automatic model_eval();
    bit fresh;
    int i;
    e_ready = '0;
    g_idx.delete();
    if (!rst && m_init == 0 && !hold) begin
      for (int k = 0; k < NR; k++) begin
        i = (m_rr + k) % NR;
        fresh = 1;
        foreach (g_idx[j]) if (a[g_idx[j]] == a[i]) fresh = 0;
        if (v[i] && g_idx.size() < NW && fresh) begin
          g_idx.push_back(i);
          e_ready[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic pre();
    bus.hold = hold;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]          = v[i];
      bus.req_addr[i*AW +: AW]  = a[i];
      bus.req_data[i*DATAW +: DATAW] = d[i];
    end
    model_eval();
    #2;
  endtask

  task automatic tick();
    s_wenb = bus.WEnb; s_waddr = bus.WAddr; s_wdata = bus.WData;
    @(posedge clk);
    for (int p = 0; p < NW; p++) begin
      if (s_wenb[p]) dut_mem[s_waddr[p*AW +: AW]] = s_wdata[p*DATAW +: DATAW];
      if (e_wenb[p]) ref_mem[e_waddr[p]] = e_wdata[p];
    end
    if (rst) model_reset();
    else if (m_init != 0) begin
      e_wenb = 2'b01; e_waddr[0] = AW'(m_cnt); e_wdata[0] = '0;
      m_cnt++;
      if (m_cnt == MEMD) begin m_init = 0; e_done = 1'b1; end
    end else begin
      e_done = 1'b1;
      for (int p = 0; p < NW; p++) begin
        if (p < g_idx.size()) begin
          e_wenb[p] = 1'b1; e_waddr[p] = a[g_idx[p]]; e_wdata[p] = d[g_idx[p]];
        end else e_wenb[p] = 1'b0;
      end
      if (g_idx.size() > 0) m_rr = (g_idx[g_idx.size()-1] + 1) % NR;
    end
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin v[i] = 1'b0; a[i] = '0; d[i] = '0; end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) begin v[i] = 1'b1; a[i] = AW'(i); d[i] = $urandom; end
    rst = 1'b1;
    pre();
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", bus.req_ready); end
    tick();
    checks++;
    if (bus.WEnb !== 2'b00 || bus.WAddr !== '0 || bus.WData !== '0 || bus.init_done !== 1'b0) begin
      errors++; $display("FAIL reset_outputs wenb=%b waddr=%h wdata=%h done=%b want all 0", bus.WEnb, bus.WAddr, bus.WData, bus.init_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_init();
    for (int c = 0; c < MEMD; c++) begin
      for (int i = 0; i < NR; i++) v[i] = 1'($urandom_range(0, 1));
      pre();
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL init_ready c=%0d got %b want 0000", c, bus.req_ready); end
      tick();
      checks++;
      if (bus.WEnb !== 2'b01 || bus.WAddr[AW-1:0] !== AW'(c) || bus.WData[DATAW-1:0] !== '0 ||
          bus.init_done !== (c == MEMD - 1) || bus.WAddr !== exp_waddr()) begin
        errors++; $display("FAIL init_fill c=%0d wenb=%b waddr=%h wdata=%h done=%b want wenb=01 addr0=%0d", c, bus.WEnb, bus.WAddr, bus.WData, bus.init_done, c);
      end
    end
    clear_reqs();
  endtask

  // Requests drop valid once granted; runs ncyc cycles with full per-cycle checks.
  task automatic run_cycles(input string name, input int ncyc, output logic [NR-1:0] first_ready);
    first_ready = 'x;
    for (int n = 0; n < ncyc; n++) begin
      pre();
      if (n == 0) first_ready = bus.req_ready;
      checks++; if (bus.req_ready !== e_ready) begin errors++; $display("FAIL %s_ready n=%0d got %b want %b", name, n, bus.req_ready, e_ready); end
      tick();
      checks++;
      if (bus.WEnb !== e_wenb || bus.WAddr !== exp_waddr() || bus.WData !== exp_wdata() || bus.init_done !== e_done) begin
        errors++; $display("FAIL %s_out n=%0d wenb=%b/%b waddr=%h/%h wdata=%h/%h done=%b", name, n, bus.WEnb, e_wenb, bus.WAddr, exp_waddr(), bus.WData, exp_wdata(), bus.init_done);
      end
      for (int i = 0; i < NR; i++) if (e_ready[i]) v[i] = 1'b0;
    end
  endtask

  task automatic test_distinct();
    logic [NR-1:0] fr;
    for (int i = 0; i < NR; i++) begin v[i] = 1'b1; a[i] = AW'(i + 1); d[i] = $urandom; end
    run_cycles("distinct", 3, fr);
    checks++; if (fr !== 4'b0011) begin errors++; $display("FAIL distinct_first got %b want 0011", fr); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (dut_mem[i+1] !== d[i]) begin errors++; $display("FAIL distinct_mem addr=%0d got %h want %h", i + 1, dut_mem[i+1], d[i]); end
    end
    clear_reqs();
  endtask

  task automatic test_same_addr();
    logic [NR-1:0] fr;
    v[0] = 1'b1; a[0] = 4'd5; d[0] = 32'hA;
    v[1] = 1'b1; a[1] = 4'd5; d[1] = 32'hB;
    run_cycles("same_addr", 4, fr);
    checks++; if (fr !== 4'b0001) begin errors++; $display("FAIL same_addr_first got %b want 0001", fr); end
    checks++; if (dut_mem[5] !== 32'hB) begin errors++; $display("FAIL same_addr_mem got %h want 0000000b", dut_mem[5]); end
    clear_reqs();
  endtask

  task automatic test_hold();
    logic [NR-1:0] fr;
    for (int i = 0; i < NR; i++) begin v[i] = 1'b1; a[i] = AW'(8 + i); d[i] = $urandom; end
    hold = 1'b1;
    run_cycles("hold", 3, fr);
    checks++; if (fr !== 4'b0000) begin errors++; $display("FAIL hold_ready got %b want 0000", fr); end
    hold = 1'b0;
    run_cycles("hold_release", 3, fr);
    clear_reqs();
  endtask

  task automatic test_single_req();
    for (int n = 0; n < 5; n++) begin
      v[3] = 1'b1; a[3] = AW'(n + 10); d[3] = $urandom;
      pre();
      checks++; if (bus.req_ready !== 4'b1000 || e_ready !== 4'b1000) begin errors++; $display("FAIL single_ready n=%0d got %b want 1000", n, bus.req_ready); end
      tick();
      checks++;
      if (bus.WEnb !== 2'b01 || bus.WAddr[AW-1:0] !== a[3] || bus.WData[DATAW-1:0] !== d[3] || bus.WAddr !== exp_waddr()) begin
        errors++; $display("FAIL single_out n=%0d wenb=%b waddr=%h wdata=%h want 01 %h %h", n, bus.WEnb, bus.WAddr, bus.WData, a[3], d[3]);
      end
    end
    clear_reqs();
  endtask

  task automatic test_random();
    int bad;
    for (int n = 0; n < 300; n++) begin
      hold = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!v[i] && $urandom_range(0, 2) != 0) begin
          v[i] = 1'b1; a[i] = AW'($urandom_range(0, 5)); d[i] = $urandom;
        end
      end
      pre();
      checks++; if (bus.req_ready !== e_ready) begin errors++; $display("FAIL random_ready n=%0d got %b want %b", n, bus.req_ready, e_ready); end
      tick();
      checks++;
      if (bus.WEnb !== e_wenb || bus.WAddr !== exp_waddr() || bus.WData !== exp_wdata()) begin
        errors++; $display("FAIL random_out n=%0d wenb=%b/%b waddr=%h/%h wdata=%h/%h", n, bus.WEnb, e_wenb, bus.WAddr, exp_waddr(), bus.WData, exp_wdata());
      end
      for (int i = 0; i < NR; i++) if (e_ready[i]) v[i] = 1'b0;
    end
    hold = 1'b0;
    clear_reqs();
    pre(); tick();
    bad = 0;
    for (int k = 0; k < MEMD; k++) if (dut_mem[k] !== ref_mem[k]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL random_mem %0d words differ, want 0", bad); end
  endtask

  task automatic test_rst_mid();
    logic [NR-1:0] fr;
    int bad;
    v[0] = 1'b1; a[0] = 4'd7; d[0] = 32'h55;
    run_cycles("rst_mid_hs", 1, fr);
    checks++; if (fr !== 4'b0001) begin errors++; $display("FAIL rst_mid_hs got %b want 0001", fr); end
    for (int i = 0; i < NR; i++) begin v[i] = 1'b1; a[i] = AW'(12 + i); end
    rst = 1'b1;
    pre();
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid_ready got %b want 0000", bus.req_ready); end
    tick();
    rst = 1'b0;
    checks++; if (dut_mem[7] !== 32'h55) begin errors++; $display("FAIL rst_mid_mem7 got %h want 00000055", dut_mem[7]); end
    checks++; if (bus.WEnb !== 2'b00 || bus.init_done !== 1'b0) begin errors++; $display("FAIL rst_mid_clear wenb=%b done=%b want 00 0", bus.WEnb, bus.init_done); end
    run_cycles("rst_mid_init", MEMD + 1, fr);
    bad = 0;
    for (int k = 0; k < MEMD; k++) if (dut_mem[k] !== 32'h0) bad++;
    checks++; if (bad != 0 || dut_mem[7] !== 32'h0) begin errors++; $display("FAIL rst_mid_zero mem7=%h nonzero=%0d want 0", dut_mem[7], bad); end
    clear_reqs();
  endtask

  initial begin
    clear_reqs();
    model_reset();
    for (int k = 0; k < MEMD; k++) begin dut_mem[k] = 'x; ref_mem[k] = 'x; end
    @(posedge clk); #1;
    test_reset();
    test_init();
    test_distinct();
    test_same_addr();
    test_hold();
    test_single_req();
    test_random();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
